// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and UART-side AXI4-Stream bundle
// for the UART transmit arbiter.
interface uart_tx_arbiter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int PORTS      = 4
);
   logic [PORTS*DATA_WIDTH-1:0] input_axis_tdata;
   logic [PORTS-1:0]            input_axis_tvalid;
   logic [PORTS-1:0]            input_axis_tlast;
   logic [PORTS-1:0]            input_axis_tready;
   logic [DATA_WIDTH-1:0]       output_axis_tdata;
   logic                        output_axis_tvalid;
   logic                        output_axis_tready;

   modport master (
      output input_axis_tdata,
      output input_axis_tvalid,
      output input_axis_tlast,
      input  input_axis_tready,
      input  output_axis_tdata,
      input  output_axis_tvalid,
      output output_axis_tready
   );

   modport slave (
      input  input_axis_tdata,
      input  input_axis_tvalid,
      input  input_axis_tlast,
      output input_axis_tready,
      output output_axis_tdata,
      output output_axis_tvalid,
      input  output_axis_tready
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-aware round-robin share of one UART AXI4-Stream TX.
// Define UART_ARB_TIMEOUT_EN to revoke grants stalled for TIMEOUT_CYCLES.
module uart_tx_arbiter #(
   parameter int DATA_WIDTH     = 8,
   parameter int PORTS          = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   uart_tx_arbiter_if.slave         axis,
   output logic [PORTS-1:0]         grant,
   output logic                     grant_valid,
   output logic [$clog2(PORTS)-1:0] grant_index,
   output logic                     timeout_event
);
   localparam int IW = $clog2(PORTS);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                state_q, state_d;
   logic [IW-1:0]         ptr_q, ptr_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [IW-1:0]         pick;
   logic                  any_req;
   logic                  beat;
   logic                  last_beat;
   logic                  revoke;
   logic [DATA_WIDTH-1:0] mux_data;

   if (PORTS < 2 || PORTS > 16) begin : g_bad_ports
      $error("uart_tx_arbiter: PORTS must be 2..16");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("uart_tx_arbiter: TIMEOUT_CYCLES must be 1..65535");
   end

   // Scan upward from ptr+1 so the last port served has lowest priority.
   always_comb begin
      logic [IW-1:0] j;
      j       = '0;
      pick    = ptr_q;
      any_req = 1'b0;
      for (int k = 1; k <= PORTS; k++) begin
         j = IW'((int'(ptr_q) + k) % PORTS);
         if (!any_req && axis.input_axis_tvalid[j]) begin
            pick    = j;
            any_req = 1'b1;
         end
      end
   end

   assign beat      = (state_q == GRANT) &&
                      axis.input_axis_tvalid[idx_q] &&
                      axis.output_axis_tready;
   assign last_beat = beat && axis.input_axis_tlast[idx_q];

   always_comb begin
      grant                  = '0;
      axis.input_axis_tready = '0;
      mux_data               = '0;
      for (int i = 0; i < PORTS; i++) begin
         if (idx_q == IW'(i)) begin
            grant[i] = (state_q == GRANT);
            mux_data = axis.input_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
         axis.input_axis_tready[i] = grant[i] && axis.output_axis_tready;
      end
   end

   assign axis.output_axis_tdata  = mux_data;
   assign axis.output_axis_tvalid = (state_q == GRANT) &&
                                    axis.input_axis_tvalid[idx_q];
   assign grant_valid             = (state_q == GRANT);
   assign grant_index             = idx_q;

`ifdef UART_ARB_TIMEOUT_EN
   logic [15:0] stall_q, stall_d;
   logic        timeout_q;

   // UART backpressure (tvalid high, tready low) holds the count.
   always_comb begin
      stall_d = '0;
      revoke  = 1'b0;
      if (state_q == GRANT) begin
         if (!axis.input_axis_tvalid[idx_q]) begin
            if (stall_q == 16'(TIMEOUT_CYCLES - 1)) begin
               revoke = 1'b1;
            end else begin
               stall_d = stall_q + 16'd1;
            end
         end else if (!beat) begin
            stall_d = stall_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         stall_q   <= stall_d;
         timeout_q <= revoke;
      end
   end

   assign timeout_event = timeout_q;
`else
   assign revoke        = 1'b0;
   assign timeout_event = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d = GRANT;
               idx_d   = pick;
            end
         end
         GRANT: begin
            if (last_beat || revoke) begin
               state_d = IDLE;
               ptr_d   = idx_q;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= IW'(PORTS - 1);
         idx_q   <= IW'(PORTS - 1);
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vector table plus packet-level sequences
// for uart_tx_arbiter (4 ports, 8-bit beats).
module tb_uart_tx_arbiter;
   localparam int DW = 8;
   localparam int NP = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.DATA_WIDTH(DW), .PORTS(NP)) bus ();

   logic [NP-1:0] grant;
   logic          grant_valid;
   logic [1:0]    grant_index;
   logic          timeout_event;

   uart_tx_arbiter #(
      .DATA_WIDTH(DW),
      .PORTS(NP),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .axis(bus),
      .grant(grant),
      .grant_valid(grant_valid),
      .grant_index(grant_index),
      .timeout_event(timeout_event)
   );

   typedef struct {
      logic [3:0]  v;
      logic [3:0]  l;
      logic        ordy;
      logic [31:0] d;
      logic [3:0]  eg;
      logic        egv;
      logic [1:0]  eidx;
      logic [3:0]  erdy;
      logic        eov;
      logic [7:0]  ed;
   } vec_t;

   typedef struct {
      logic [7:0] d;
      logic       l;
   } beat_t;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   beat_t         pq[NP][$];
   logic [NP-1:0] hold;
   logic [7:0]    log_d[$];
   logic [1:0]    log_p[$];
   int            log_c[$];

   logic [NP-1:0] s_grant, s_rdy;
   logic          s_ov, s_te;
   int            s_cyc;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NP; i++) begin
         if (pq[i].size() > 0 && !hold[i]) begin
            bus.input_axis_tvalid[i]         = 1'b1;
            bus.input_axis_tlast[i]          = pq[i][0].l;
            bus.input_axis_tdata[i*DW +: DW] = pq[i][0].d;
         end else begin
            bus.input_axis_tvalid[i]         = 1'b0;
            bus.input_axis_tlast[i]          = 1'b0;
            bus.input_axis_tdata[i*DW +: DW] = '0;
         end
      end
   endtask

   // Called at posedge+1; samples mid-cycle, then advances one clock.
   task automatic step();
      logic [NP-1:0] fired;
      #3;
      fired   = bus.input_axis_tvalid & bus.input_axis_tready;
      s_grant = grant;
      s_rdy   = bus.input_axis_tready;
      s_ov    = bus.output_axis_tvalid;
      s_te    = timeout_event;
      s_cyc   = cyc;
      if (bus.output_axis_tvalid && bus.output_axis_tready) begin
         log_d.push_back(bus.output_axis_tdata);
         log_p.push_back(grant_index);
         log_c.push_back(cyc);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NP; i++)
         if (fired[i]) void'(pq[i].pop_front());
      cyc++;
      drive();
   endtask

   task automatic run_until(int n, int budget, string name);
      int b;
      b = 0;
      while (log_d.size() < n && b < budget) begin
         step();
         b++;
      end
      check({name, " beat count"}, 32'(log_d.size()), 32'(n));
   endtask

   task automatic exp_beat(string name, int i, logic [7:0] d, logic [1:0] p);
      if (i >= log_d.size()) begin
         check({name, " missing beat"}, 32'(log_d.size()), 32'(i + 1));
      end else begin
         check($sformatf("%s[%0d] data", name, i), 32'(log_d[i]), 32'(d));
         check($sformatf("%s[%0d] port", name, i), 32'(log_p[i]), 32'(p));
      end
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      hold = '0;
      for (int i = 0; i < NP; i++) pq[i].delete();
      bus.output_axis_tready = 1'b1;
      drive();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      log_d.delete();
      log_p.delete();
      log_c.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[14];
      logic ok_g, ok_r, ok_v;
      int   te_n, te_cyc, hs_cyc;

      //       v        l        rdy   d              eg       gv    idx   erdy     eov   ed
      vt[0]  = '{4'b0000, 4'b0000, 1'b1, 32'h0000_0000, 4'b0000, 1'b0, 2'd3, 4'b0000, 1'b0, 8'h00};
      vt[1]  = '{4'b0100, 4'b0000, 1'b1, 32'h0041_0000, 4'b0000, 1'b0, 2'd3, 4'b0000, 1'b0, 8'h00};
      vt[2]  = '{4'b0100, 4'b0000, 1'b1, 32'h0041_0000, 4'b0100, 1'b1, 2'd2, 4'b0100, 1'b1, 8'h41};
      vt[3]  = '{4'b0100, 4'b0000, 1'b1, 32'h0042_0000, 4'b0100, 1'b1, 2'd2, 4'b0100, 1'b1, 8'h42};
      vt[4]  = '{4'b0100, 4'b0100, 1'b0, 32'h0043_0000, 4'b0100, 1'b1, 2'd2, 4'b0000, 1'b1, 8'h43};
      vt[5]  = '{4'b0100, 4'b0100, 1'b1, 32'h0043_0000, 4'b0100, 1'b1, 2'd2, 4'b0100, 1'b1, 8'h43};
      vt[6]  = '{4'b0000, 4'b0000, 1'b1, 32'h0000_0000, 4'b0000, 1'b0, 2'd2, 4'b0000, 1'b0, 8'h00};
      vt[7]  = '{4'b1010, 4'b0000, 1'b1, 32'hB3A2_9180, 4'b0000, 1'b0, 2'd2, 4'b0000, 1'b0, 8'h00};
      vt[8]  = '{4'b1010, 4'b1000, 1'b1, 32'hB3A2_9180, 4'b1000, 1'b1, 2'd3, 4'b1000, 1'b1, 8'hB3};
      vt[9]  = '{4'b1010, 4'b1000, 1'b1, 32'hB3A2_9180, 4'b0000, 1'b0, 2'd3, 4'b0000, 1'b0, 8'h00};
      vt[10] = '{4'b1010, 4'b0010, 1'b1, 32'hB3A2_9180, 4'b0010, 1'b1, 2'd1, 4'b0010, 1'b1, 8'h91};
      vt[11] = '{4'b1010, 4'b0000, 1'b1, 32'hB3A2_9180, 4'b0000, 1'b0, 2'd1, 4'b0000, 1'b0, 8'h00};
      vt[12] = '{4'b1010, 4'b0000, 1'b1, 32'hB3A2_9180, 4'b1000, 1'b1, 2'd3, 4'b1000, 1'b1, 8'hB3};
      vt[13] = '{4'b0000, 4'b0000, 1'b1, 32'hB3A2_9180, 4'b1000, 1'b1, 2'd3, 4'b1000, 1'b0, 8'h00};

      bus.input_axis_tdata   = '0;
      bus.input_axis_tvalid  = '0;
      bus.input_axis_tlast   = '0;
      bus.output_axis_tready = 1'b1;
      hold = '0;
      do_reset();

      for (int k = 0; k < 14; k++) begin
         bus.input_axis_tvalid  = vt[k].v;
         bus.input_axis_tlast   = vt[k].l;
         bus.input_axis_tdata   = vt[k].d;
         bus.output_axis_tready = vt[k].ordy;
         #3;
         check($sformatf("v%0d grant", k), 32'(grant), 32'(vt[k].eg));
         check($sformatf("v%0d grant_valid", k), 32'(grant_valid), 32'(vt[k].egv));
         check($sformatf("v%0d grant_index", k), 32'(grant_index), 32'(vt[k].eidx));
         check($sformatf("v%0d tready", k), 32'(bus.input_axis_tready), 32'(vt[k].erdy));
         check($sformatf("v%0d out_tvalid", k), 32'(bus.output_axis_tvalid), 32'(vt[k].eov));
         check($sformatf("v%0d timeout_event", k), 32'(timeout_event), 32'd0);
         if (vt[k].eov)
            check($sformatf("v%0d out_tdata", k), 32'(bus.output_axis_tdata), 32'(vt[k].ed));
         @(posedge clk);
         #1;
      end

      // Rotation with all ports requesting two 2-beat packets each.
      do_reset();
      for (int p = 0; p < NP; p++)
         for (int pk = 0; pk < 2; pk++)
            for (int b = 0; b < 2; b++)
               pq[p].push_back('{8'(16 * p + b), 1'(b == 1)});
      drive();
      run_until(10, 100, "rot");
      for (int i = 0; i < 10; i++)
         exp_beat("rot", i, 8'(16 * ((i / 2) % 4) + i % 2), 2'((i / 2) % 4));
      if (log_c.size() >= 10)
         for (int i = 1; i < 10; i++)
            check($sformatf("rot gap%0d", i), 32'(log_c[i] - log_c[i-1]),
                  (i % 2 == 1) ? 32'd1 : 32'd2);

      // UART backpressure on port 1 mid-packet while port 3 waits.
      do_reset();
      pq[1].push_back('{8'h51, 1'b0});
      pq[1].push_back('{8'h52, 1'b0});
      pq[1].push_back('{8'h53, 1'b1});
      drive();
      step();
      step();
      bus.output_axis_tready = 1'b0;
      pq[3].push_back('{8'h77, 1'b1});
      drive();
      ok_g = 1'b1;
      ok_r = 1'b1;
      repeat (500) begin
         step();
         if (s_grant !== 4'b0010) ok_g = 1'b0;
         if (s_rdy[3] !== 1'b0) ok_r = 1'b0;
      end
      check("bp grant held", 32'(ok_g), 32'd1);
      check("bp port3 tready low", 32'(ok_r), 32'd1);
      bus.output_axis_tready = 1'b1;
      run_until(4, 50, "bp");
      exp_beat("bp", 0, 8'h51, 2'd1);
      exp_beat("bp", 1, 8'h52, 2'd1);
      exp_beat("bp", 2, 8'h53, 2'd1);
      exp_beat("bp", 3, 8'h77, 2'd3);

      // Port 0 drops tvalid mid-packet while port 1 requests.
      do_reset();
      pq[0].push_back('{8'hA0, 1'b0});
      pq[0].push_back('{8'hA1, 1'b0});
      pq[0].push_back('{8'hA2, 1'b1});
      pq[1].push_back('{8'hB0, 1'b1});
      drive();
      step();
      step();
      hold[0] = 1'b1;
      drive();
      ok_g = 1'b1;
      ok_v = 1'b1;
      repeat (5) begin
         step();
         if (s_grant !== 4'b0001) ok_g = 1'b0;
         if (s_ov !== 1'b0) ok_v = 1'b0;
      end
      check("drop grant held", 32'(ok_g), 32'd1);
      check("drop out_tvalid low", 32'(ok_v), 32'd1);
      hold[0] = 1'b0;
      drive();
      run_until(4, 30, "drop");
      exp_beat("drop", 0, 8'hA0, 2'd0);
      exp_beat("drop", 1, 8'hA1, 2'd0);
      exp_beat("drop", 2, 8'hA2, 2'd0);
      exp_beat("drop", 3, 8'hB0, 2'd1);

      // Reset pulse during beat 2 of a 4-beat packet on port 3.
      do_reset();
      pq[3].push_back('{8'hC0, 1'b0});
      pq[3].push_back('{8'hC1, 1'b0});
      pq[3].push_back('{8'hC2, 1'b0});
      pq[3].push_back('{8'hC3, 1'b1});
      drive();
      step();
      step();
      rst = 1'b1;
      bus.output_axis_tready = 1'b0;
      step();
      rst = 1'b0;
      pq[0].push_back('{8'hD0, 1'b1});
      drive();
      step();
      check("rst grant", 32'(s_grant), 32'd0);
      check("rst out_tvalid", 32'(s_ov), 32'd0);
      bus.output_axis_tready = 1'b1;
      log_d.delete();
      log_p.delete();
      log_c.delete();
      run_until(1, 20, "rst");
      exp_beat("rst next", 0, 8'hD0, 2'd0);

      // Port 2 stalls mid-packet; port 0 requests afterwards.
      do_reset();
      pq[2].push_back('{8'hE0, 1'b0});
      pq[2].push_back('{8'hE1, 1'b1});
      drive();
      step();
      step();
      hs_cyc = (log_c.size() > 0) ? log_c[0] : -1;
      hold[2] = 1'b1;
      pq[0].push_back('{8'hF0, 1'b1});
      drive();
      te_n   = 0;
      te_cyc = -1;
      repeat (30) begin
         step();
         if (s_te === 1'b1) begin
            te_n++;
            if (te_cyc < 0) te_cyc = s_cyc;
         end
      end
`ifdef UART_ARB_TIMEOUT_EN
      check("to pulse count", 32'(te_n), 32'd1);
      check("to pulse delay", 32'(te_cyc - hs_cyc), 32'd17);
      exp_beat("to next", 1, 8'hF0, 2'd0);
`else
      check("to pulse count", 32'(te_n), 32'd0);
      check("to grant held", 32'(s_grant), 32'b0100);
      check("to beat count", 32'(log_d.size()), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin, packet-aware arbiter that shares one AXI4-Stream UART transmit channel among PORTS requesters.
- Sits between several producers (CPU debug path, trace, boot loader) and the UART's input_axis_* transmit interface.
- Grant is held from the first beat to the tlast beat, so packets never interleave on txd.
- Datapath is combinational pass-through. Only the grant state is registered.

Parameters:
DATA_WIDTH, 8, byte width per beat; must match the UART's DATA_WIDTH.
PORTS, 4, number of requesters (2..16).
TIMEOUT_CYCLES, 1024, stall limit used only when UART_ARB_TIMEOUT_EN is defined (1..65535).

Ports:
clk  input  1  single clock for all logic.
rst  input  1  synchronous, active-high reset.
input_axis_tdata  input  PORTS*DATA_WIDTH  flattened requester data; port i occupies [i*DATA_WIDTH +: DATA_WIDTH].
input_axis_tvalid  input  PORTS  per-port valid.
input_axis_tlast  input  PORTS  per-port end-of-packet marker.
input_axis_tready  output  PORTS  per-port ready.
output_axis_tdata  output  DATA_WIDTH  to UART input_axis_tdata.
output_axis_tvalid  output  1  to UART input_axis_tvalid.
output_axis_tready  input  1  from UART input_axis_tready.
grant  output  PORTS  one-hot current grant; all zero when idle.
grant_valid  output  1  a grant is held.
grant_index  output  $clog2(PORTS)  encoded index of the granted port; holds last value when idle.
timeout_event  output  1  one-cycle pulse when a grant is revoked by timeout; constant 0 without the macro.

Behaviour:
- Reset (rst high at a clk edge):
  - grant=0, grant_valid=0, grant_index=PORTS-1, timeout_event=0.
  - Round-robin pointer = PORTS-1, so port 0 has first priority.
  - Reset asserted mid-packet drops the grant at that edge. The remaining beats of the in-flight packet are not forwarded. The UART completes any byte it has already accepted.
- State machine, two states:
  - IDLE: grant_valid=0. All input tready=0. output_axis_tvalid=0.
    - If any input_axis_tvalid is high, select the first requesting port scanning upward from pointer+1 with wrap-around (modulo PORTS).
    - Register grant/grant_index at the next edge and go to GRANT.
    - Arbitration latency: 1 cycle from tvalid to grant.
  - GRANT:
    - output_axis_tdata = data of the granted port; output_axis_tvalid = its tvalid.
    - input_axis_tready[grant_index] = output_axis_tready. All other tready = 0.
    - On a handshake (tvalid && tready) with tlast=1: return to IDLE at that edge and set pointer = grant_index.
    - A tvalid drop mid-packet does not release the grant.
- Inter-packet gap: exactly one idle cycle between a tlast handshake and the next grant. This is intentional; the UART's byte time dominates.
- Fairness: a port that just finished has lowest priority in the next arbitration. With all PORTS requesting continuously, grants rotate 0,1,2,...,PORTS-1,0.
- Single-beat packet (tlast on first beat) is legal: one beat forwarded, then release.
- No combinational path from any input tvalid to any input tready. The only combinational path is output_axis_tready to the granted port's tready.
- No buffering and no data modification. The beat order on the output equals the beat order of the granted input.

Optional Feature:
- Macro UART_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit stall counter runs in GRANT. It clears on every granted handshake and on entering GRANT.
  - It increments each cycle the granted port has tvalid=0.
  - When the counter reaches TIMEOUT_CYCLES, the grant is revoked at that edge: go to IDLE, pointer = grant_index, timeout_event pulses high for one cycle.
  - Cycles with tvalid=1 but output_axis_tready=0 are UART backpressure and do not count.
- When not defined: no counter logic is present, the grant is held indefinitely until tlast, and timeout_event is tied to 0.

Test Plan:
- Reset, then port 2 sends a 3-byte packet 0x41,0x42,0x43 (tlast on 0x43). Required: grant=0b0100 one cycle after tvalid; UART receives exactly those bytes in order; grant_valid=0 the cycle after the tlast handshake.
- All 4 ports request continuously with 2-byte packets, data = 0x10*port + beat. Required: output order is ports 0,1,2,3,0; no packet interleaving; exactly one idle cycle between packets.
- Port 1 mid-packet with output_axis_tready held 0 for 500 cycles while port 3 requests. Required: grant stays on port 1; input_axis_tready[3]=0 throughout; port 1's packet completes before port 3 is granted.
- Port 0 drops tvalid for 5 cycles mid-packet while port 1 requests. Required: grant is held on port 0; port 1 is granted only after port 0's tlast.
- rst pulsed for 1 cycle during beat 2 of a 4-beat packet on port 3. Required: grant=0 and output_axis_tvalid=0 after the edge; next arbitration with ports 0 and 3 requesting grants port 0.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: port 2 stalls mid-packet. Required: timeout_event pulses 16 cycles after its last handshake; port 0 is granted next. Without the macro: no release and timeout_event=0.
